// File: rtl/mem_arbiter.sv
// Memory-port arbiter: I-cache fill, D-cache fill, writeback and DMA share one memory port.
// Define ARB_RR_EN for round-robin between I/D fills; otherwise D-fill has fixed priority.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        readM1,
  input  logic        readM2,
  input  logic        writeM2,
  input  logic [15:0] address1,
  input  logic [15:0] address2,
  input  logic        evict1,
  input  logic        evict2,
  input  logic [15:0] evicted1_address,
  input  logic [15:0] evicted2_address,
  input  logic        dmaReq,
  input  logic        memDone,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] memAddr,
  output logic [1:0]  memSel,
  output logic [1:0]  instReady,
  output logic [1:0]  memReadReady,
  output logic [1:0]  memWriteReady,
  output logic        dmaGrant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MEM, DONE, DMA} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
  localparam logic [1:0] SEL_IFILL = 2'd0;
  localparam logic [1:0] SEL_DFILL = 2'd1;
  localparam logic [1:0] SEL_WB    = 2'd2;
  localparam logic [1:0] SEL_DMA   = 2'd3;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_sel_q, mem_sel_d;
  logic [1:0]  inst_rdy_q, inst_rdy_d;
  logic [1:0]  rd_rdy_q, rd_rdy_d;
  logic [1:0]  wr_rdy_q, wr_rdy_d;
  logic        dma_grant_q, dma_grant_d;
  logic        busy_q, busy_d;
  logic        grant_dma, aged, fill_any, pick_d;

  // evict2 alone chooses the writeback source; evict1 carries no extra information
  logic unused_evict1;
  assign unused_evict1 = evict1;

`ifdef ARB_RR_EN
  // 0: last fill served was IFILL, 1: DFILL
  logic rr_q, rr_d;
  assign pick_d = readM2 & (~readM1 | ~rr_q);
`else
  assign pick_d = readM2;
`endif

  assign fill_any = readM1 | readM2;
  assign aged     = dmaReq & (wait_q >= MAX_W);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_sel_d   = mem_sel_q;
    dma_grant_d = dma_grant_q;
    inst_rdy_d  = 2'd0;
    rd_rdy_d    = 2'd0;
    wr_rdy_d    = 2'd0;
    grant_dma   = 1'b0;
`ifdef ARB_RR_EN
    rr_d        = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (aged) begin
          grant_dma = 1'b1;
        end else if (writeM2) begin
          state_d     = MEM;
          mem_sel_d   = SEL_WB;
          mem_addr_d  = evict2 ? evicted2_address : evicted1_address;
          mem_write_d = 1'b1;
          mem_read_d  = 1'b0;
        end else if (fill_any) begin
          state_d     = MEM;
          mem_sel_d   = pick_d ? SEL_DFILL : SEL_IFILL;
          mem_addr_d  = pick_d ? address2 : address1;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
`ifdef ARB_RR_EN
          rr_d        = pick_d;
`endif
        end else if (dmaReq) begin
          grant_dma = 1'b1;
        end
        if (grant_dma) begin
          state_d     = DMA;
          mem_sel_d   = SEL_DMA;
          dma_grant_d = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      MEM: begin
        if (memDone) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          inst_rdy_d  = (mem_sel_q == SEL_IFILL) ? 2'd1 : 2'd0;
          rd_rdy_d    = (mem_sel_q == SEL_DFILL) ? 2'd1 : 2'd0;
          wr_rdy_d    = (mem_sel_q == SEL_WB)    ? 2'd1 : 2'd0;
        end
      end
      DONE: state_d = IDLE;
      DMA: begin
        if (!dmaReq) begin
          state_d     = IDLE;
          dma_grant_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // DMA aging counter: counts only while DMA is actually waiting
    if (!dmaReq || grant_dma)
      wait_d = 8'd0;
    else if (state_q != DMA && wait_q < MAX_W)
      wait_d = wait_q + 8'd1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      wait_q      <= 8'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_sel_q   <= 2'd0;
      inst_rdy_q  <= 2'd0;
      rd_rdy_q    <= 2'd0;
      wr_rdy_q    <= 2'd0;
      dma_grant_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_RR_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      inst_rdy_q  <= inst_rdy_d;
      rd_rdy_q    <= rd_rdy_d;
      wr_rdy_q    <= wr_rdy_d;
      dma_grant_q <= dma_grant_d;
      busy_q      <= busy_d;
`ifdef ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign memRead       = mem_read_q;
  assign memWrite      = mem_write_q;
  assign memAddr       = mem_addr_q;
  assign memSel        = mem_sel_q;
  assign instReady     = inst_rdy_q;
  assign memReadReady  = rd_rdy_q;
  assign memWriteReady = wr_rdy_q;
  assign dmaGrant      = dma_grant_q;
  assign busy          = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8: cycles a pending DMA request waits before it pre-empts cache traffic at the next idle slot. Legal range 1..255.
REQ-002 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 readM1  in  1  I-cache fill request; level, held until instReady==1 is seen.
REQ-005 readM2  in  1  D-cache fill request; level, same holding rule as readM1.
REQ-006 writeM2  in  1  dirty-block writeback request; level, held until memWriteReady==1 is seen.
REQ-007 address1, address2  in  16 each  I-cache and D-cache miss addresses.
REQ-008 evict1, evict2  in  1 each  select the source of the writeback address.
REQ-009 evicted1_address, evicted2_address  in  16 each  writeback addresses.
REQ-010 dmaReq  in  1  DMA bus request; level.
REQ-011 memDone  in  1  memory block-transfer completion; one-cycle pulse.
REQ-012 memRead, memWrite  out  1 each  memory command.
REQ-013 memAddr  out  16  memory block address.
REQ-014 memSel  out  2  current owner: 0 = IFILL, 1 = DFILL, 2 = WB, 3 = DMA.
REQ-015 instReady, memReadReady, memWriteReady  out  2 each  completion status: value 1 for one cycle, otherwise 0.
REQ-016 dmaGrant  out  1  bus granted to DMA.
REQ-017 busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM has four states: IDLE, MEM, DONE, DMA. All outputs are registered.
REQ-019 IDLE selection priority:
- DMA first, if dmaReq=1 and the wait counter has reached MAX_WAIT;
- then WB, if writeM2=1;
- then the fill selection of REQ-029;
- then DMA, if dmaReq=1;
- else stay in IDLE.
REQ-020 Cache grant (IDLE->MEM):
- latch memAddr = address1 (IFILL) or address2 (DFILL);
- for WB, memAddr = evicted2_address if evict2=1, else evicted1_address;
- set memSel to the owner; memRead=1 for fills, memWrite=1 for WB.
- The command is visible one cycle after the request was sampled.
REQ-021 MEM: memAddr, memSel, memRead and memWrite are held constant until memDone=1 is sampled.
REQ-022 MEM with memDone=1 -> DONE: clear memRead/memWrite and drive the owner's ready output (instReady / memReadReady / memWriteReady) to 1.
REQ-023 DONE lasts exactly one cycle, then returns to IDLE with the ready output back at 0. This gives the cache one edge to drop its request before re-arbitration.
REQ-024 memDone sampled in IDLE, DONE or DMA is ignored.
REQ-025 DMA grant (IDLE->DMA): dmaGrant=1, memSel=3, memRead=memWrite=0; the wait counter clears.
REQ-026 DMA with dmaReq=0 sampled: dmaGrant=0 on that edge, return to IDLE. Cache requests arriving during DMA stay pending.
REQ-027 Wait counter (8-bit):
- increments each cycle that dmaReq=1 and the state is not DMA;
- saturates at MAX_WAIT;
- clears when dmaReq=0 or on a DMA grant.
REQ-028 Simultaneous writeM2 and readM2: WB is always served before DFILL.

Configuration
REQ-029 Macro ARB_RR_EN selects the fill policy:
- Defined: IFILL/DFILL are round-robin via a 1-bit last-fill flag (reset value: I). When both are pending, the fill not served last wins. The flag updates on each fill grant.
- Undefined: DFILL has fixed priority over IFILL.

Reset
REQ-030 Reset=1 at a rising edge forces IDLE from any state, including MEM and DMA. An in-flight transfer is abandoned with no ready pulse.
REQ-031 Reset values of all outputs and counters:
- memRead, memWrite, dmaGrant, busy: 0;
- instReady, memReadReady, memWriteReady: 0;
- memAddr: 0; memSel: 0;
- wait counter: 0; round-robin flag: I.

Verification
REQ-032 Single fill: readM1=1, address1=0x0123, memDone 3 cycles after the command appears.
- Required: memRead=1, memAddr=0x0123, memSel=0; instReady=1 for exactly one cycle; busy=0 two cycles after memDone.
REQ-033 Writeback then fill: writeM2=readM2=1, evict2=1, evicted2_address=0x0040, address2=0x0088.
- Required: memWrite with memAddr 0x0040 first (memWriteReady pulse), then memRead with 0x0088 (memReadReady pulse).
REQ-034 Fill policy: readM1=readM2=1 held across 3 fills.
- ARB_RR_EN defined: owner order D, I, D.
- ARB_RR_EN undefined: D, D, D.
REQ-035 DMA aging: dmaReq=1 while readM1 is re-asserted continuously, MAX_WAIT=8.
- Required: dmaGrant=1 at the first IDLE after 8 waiting cycles; dmaGrant=0 one edge after dmaReq drops.
REQ-036 Reset mid-operation: Reset=1 in MEM with memDone=1 on the same edge.
- Required: next cycle memRead=0, all ready outputs 0, busy=0.
